// File: rtl/viola_pkg.sv
// Shared definitions for the reservation-station / CDB slice: widths, tag and
// source encodings, and the operation codes issued to the reservation stations.
package viola_pkg;

    localparam int TAG_W  = 3;
    localparam int DATA_W = 32;

    localparam logic [TAG_W-1:0] TAG_NONE = '0;

    localparam logic SRC_ALU = 1'b0;
    localparam logic SRC_MEM = 1'b1;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SLT = 3'd5,
        OP_LD  = 3'd6,
        OP_ST  = 3'd7
    } rs_op_e;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } cdb_result_t;

    // Round-robin choice when both heads are valid: the source not served last.
    function automatic logic rr_pick(input logic last_grant);
        return (last_grant == SRC_MEM) ? SRC_ALU : SRC_MEM;
    endfunction

endpackage

// File: rtl/cdb_result_fifo.sv
// Small synchronous result FIFO (tag + data) with a synchronous clear; the
// pointers carry one extra MSB so full and empty are told apart on wrap.
module cdb_result_fifo #(
    parameter int TAG_W  = 3,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              push,
    input  logic [TAG_W-1:0]  push_tag,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [TAG_W-1:0]  head_tag,
    output logic [DATA_W-1:0] head_data
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [TAG_W-1:0]  tag_mem_q  [DEPTH];
    logic [DATA_W-1:0] data_mem_q [DEPTH];
    logic              do_push;
    logic              do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign do_push = push && !full && !clear;
    assign do_pop  = pop && !empty && !clear;

    assign head_tag  = tag_mem_q[rd_ptr_q[AW-1:0]];
    assign head_data = data_mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: a slot is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            tag_mem_q[wr_ptr_q[AW-1:0]]  <= push_tag;
            data_mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: buffers ALU and memory results and broadcasts one
// per cycle, round-robin. Define CDB_STATS_EN to add the stat_* counters.
module cdb_arbiter #(
    parameter int DATA_W = viola_pkg::DATA_W,
    parameter int TAG_W  = viola_pkg::TAG_W,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              alu_valid,
    input  logic [TAG_W-1:0]  alu_des,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              mem_valid,
    input  logic [TAG_W-1:0]  mem_des,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_ready,
    output logic              cdb_valid,
    output logic [TAG_W-1:0]  cdb_tag,
    output logic [DATA_W-1:0] cdb_data,
    output logic              cdb_src
`ifdef CDB_STATS_EN
    ,
    output logic [31:0]       stat_bcast,
    output logic [31:0]       stat_conflict,
    output logic [31:0]       stat_stall
`endif
);

    import viola_pkg::*;

    logic              alu_full, alu_empty, mem_full, mem_empty;
    logic              alu_push, mem_push, alu_pop, mem_pop;
    logic [TAG_W-1:0]  alu_head_tag, mem_head_tag;
    logic [DATA_W-1:0] alu_head_data, mem_head_data;

    logic              gnt_valid;
    logic              gnt_src;
    logic [TAG_W-1:0]  gnt_tag;
    logic [DATA_W-1:0] gnt_data;

    logic              cdb_valid_q, cdb_valid_d;
    logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
    logic [DATA_W-1:0] cdb_data_q, cdb_data_d;
    logic              cdb_src_q, cdb_src_d;
    logic              last_grant_q, last_grant_d;

    assign alu_ready = !alu_full;
    assign mem_ready = !mem_full;

    // Tag-0 results complete the handshake but are never stored.
    assign alu_push = alu_valid && alu_ready && !flush && (alu_des != TAG_W'(TAG_NONE));
    assign mem_push = mem_valid && mem_ready && !flush && (mem_des != TAG_W'(TAG_NONE));

    assign alu_pop = gnt_valid && (gnt_src == SRC_ALU) && !flush;
    assign mem_pop = gnt_valid && (gnt_src == SRC_MEM) && !flush;

    cdb_result_fifo #(
        .TAG_W  (TAG_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_alu_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (flush),
        .push      (alu_push),
        .push_tag  (alu_des),
        .push_data (alu_data),
        .pop       (alu_pop),
        .full      (alu_full),
        .empty     (alu_empty),
        .head_tag  (alu_head_tag),
        .head_data (alu_head_data)
    );

    cdb_result_fifo #(
        .TAG_W  (TAG_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (flush),
        .push      (mem_push),
        .push_tag  (mem_des),
        .push_data (mem_data),
        .pop       (mem_pop),
        .full      (mem_full),
        .empty     (mem_empty),
        .head_tag  (mem_head_tag),
        .head_data (mem_head_data)
    );

    always_comb begin
        gnt_valid = 1'b0;
        gnt_src   = SRC_ALU;
        if (!alu_empty && !mem_empty) begin
            gnt_valid = 1'b1;
            gnt_src   = rr_pick(last_grant_q);
        end else if (!alu_empty) begin
            gnt_valid = 1'b1;
            gnt_src   = SRC_ALU;
        end else if (!mem_empty) begin
            gnt_valid = 1'b1;
            gnt_src   = SRC_MEM;
        end
    end

    assign gnt_tag  = (gnt_src == SRC_MEM) ? mem_head_tag  : alu_head_tag;
    assign gnt_data = (gnt_src == SRC_MEM) ? mem_head_data : alu_head_data;

    // Data and source hold across idle cycles; only valid and tag return to zero.
    always_comb begin
        cdb_valid_d  = cdb_valid_q;
        cdb_tag_d    = cdb_tag_q;
        cdb_data_d   = cdb_data_q;
        cdb_src_d    = cdb_src_q;
        last_grant_d = last_grant_q;
        if (flush) begin
            cdb_valid_d = 1'b0;
            cdb_tag_d   = TAG_W'(TAG_NONE);
        end else if (gnt_valid) begin
            cdb_valid_d  = 1'b1;
            cdb_tag_d    = gnt_tag;
            cdb_data_d   = gnt_data;
            cdb_src_d    = gnt_src;
            last_grant_d = gnt_src;
        end else begin
            cdb_valid_d = 1'b0;
            cdb_tag_d   = TAG_W'(TAG_NONE);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cdb_valid_q  <= 1'b0;
            cdb_tag_q    <= '0;
            cdb_data_q   <= '0;
            cdb_src_q    <= SRC_ALU;
            last_grant_q <= SRC_MEM;
        end else begin
            cdb_valid_q  <= cdb_valid_d;
            cdb_tag_q    <= cdb_tag_d;
            cdb_data_q   <= cdb_data_d;
            cdb_src_q    <= cdb_src_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign cdb_valid = cdb_valid_q;
    assign cdb_tag   = cdb_tag_q;
    assign cdb_data  = cdb_data_q;
    assign cdb_src   = cdb_src_q;

`ifdef CDB_STATS_EN
    logic [31:0] stat_bcast_q, stat_bcast_d;
    logic [31:0] stat_conflict_q, stat_conflict_d;
    logic [31:0] stat_stall_q, stat_stall_d;

    // A double stall still counts once per cycle.
    always_comb begin
        stat_bcast_d    = stat_bcast_q;
        stat_conflict_d = stat_conflict_q;
        stat_stall_d    = stat_stall_q;
        if (gnt_valid && !flush)
            stat_bcast_d = stat_bcast_q + 32'd1;
        if (!alu_empty && !mem_empty)
            stat_conflict_d = stat_conflict_q + 32'd1;
        if ((alu_valid && !alu_ready) || (mem_valid && !mem_ready))
            stat_stall_d = stat_stall_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_bcast_q    <= '0;
            stat_conflict_q <= '0;
            stat_stall_q    <= '0;
        end else begin
            stat_bcast_q    <= stat_bcast_d;
            stat_conflict_q <= stat_conflict_d;
            stat_stall_q    <= stat_stall_d;
        end
    end

    assign stat_bcast    = stat_bcast_q;
    assign stat_conflict = stat_conflict_q;
    assign stat_stall    = stat_stall_q;
`endif

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Sole arbiter for the common data bus (CDB), the broadcast path that returns results to the reservation station operand-capture logic and the register-status tracking.
- Two producers, the ALU and the memory unit, each present a (tag, data) result. The block buffers each producer in a small FIFO and grants the bus round-robin, one result per cycle.
- Removes the current collision in which ALU and memory write-backs to the same waiting tag in the same cycle race.

Parameters:
- DATA_W, 32, result data width.
- TAG_W, 3, station tag width; tag 0 is reserved as "no producer / no broadcast".
- DEPTH, 2, entries per source FIFO; power of two, at least 2.

Ports:
- clk  in  1  clock, rising-edge active.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous pipeline flush (branch mispredict); active-high.
- alu_valid  in  1  ALU result present this cycle.
- alu_des  in  TAG_W  ALU result destination tag.
- alu_data  in  DATA_W  ALU result value.
- alu_ready  out  1  ALU FIFO can accept.
- mem_valid  in  1  memory result present.
- mem_des  in  TAG_W  memory result tag.
- mem_data  in  DATA_W  memory result value.
- mem_ready  out  1  memory FIFO can accept.
- cdb_valid  out  1  broadcast valid.
- cdb_tag  out  TAG_W  broadcast tag; 0 whenever cdb_valid=0.
- cdb_data  out  DATA_W  broadcast value.
- cdb_src  out  1  granted source: 0 = ALU, 1 = memory.

Behaviour:
- Reset (rst=0, asynchronous):
  - Both FIFOs are emptied.
  - cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_src=0.
  - last_grant is set to MEM, so the ALU wins the first contention.
  - alu_ready and mem_ready are driven 1 by combinational logic once reset is released.
- Accept:
  - x_ready = !fifo_x_full. This is combinational and does not depend on same-cycle dequeue, so there is no pass-through when a FIFO is full.
  - A result is enqueued at the rising edge when x_valid && x_ready && !flush.
  - A result with x_valid=1 and tag 0 is accepted (handshake completes) but not stored.
- Arbitration (combinational over the FIFO heads):
  - Only ALU non-empty: grant ALU.
  - Only memory non-empty: grant memory.
  - Both non-empty: grant the source that is not last_grant.
  - The granted head is popped at the same edge that registers the CDB outputs. last_grant updates only on an actual grant.
- Outputs are registered:
  - On a grant, the next edge loads cdb_valid=1, cdb_tag, cdb_data and cdb_src.
  - With no grant, the next edge loads cdb_valid=0 and cdb_tag=0; cdb_data and cdb_src hold their values.
- Latency: a result accepted at edge t into an empty, uncontended FIFO is broadcast in the cycle following edge t+1. Latency is 2 edges minimum and 3 when it loses one contention.
- Throughput: 1 broadcast per cycle. Under sustained contention each source receives exactly every other slot.
- FIFO pointers: log2(DEPTH)+1 bits; wrap-around handled by the extra MSB. Full = MSBs differ and low bits equal.
- Flush:
  - At the edge with flush=1, both FIFOs are emptied and cdb_valid and cdb_tag are set to 0.
  - Inputs presented in that cycle are discarded, although ready still reflects the pre-flush state.
  - last_grant is unchanged.
  - Reset overrides flush.
- Simultaneous events: enqueue and pop on the same FIFO in the same cycle keeps the count unchanged. Both sources may enqueue in the same cycle.

Optional Feature:
- Macro: CDB_STATS_EN.
- When defined, the block adds these outputs:
  - stat_bcast (32 bit): counts broadcasts.
  - stat_conflict (32 bit): counts cycles with both FIFO heads valid.
  - stat_stall (32 bit): counts cycles with x_valid && !x_ready for either source, so it increments by 1 even when both sources stall.
- The counters clear on reset, are unaffected by flush, and wrap at 2^32.
- When not defined, the ports and logic are absent and the behaviour is otherwise identical.

Decomposition:
- Shared package viola_pkg holds:
  - TAG_W and DATA_W.
  - TAG_NONE = 0.
  - SRC_ALU = 0 and SRC_MEM = 1.
  - The op encodings already used by the reservation station.
- One sub-module, cdb_result_fifo: a parameterised sync FIFO (push, pop, full, empty, head tag/data, clear). It is instantiated twice.

Test Plan:
- Reset release, then ALU valid, tag 3, data 0x11 at edge 1 → cdb_valid=1, tag 3, data 0x11, src 0 after edge 2; cdb idle after edge 3.
- ALU (tag 1, 0xA) and memory (tag 4, 0xB) valid in the same cycle → broadcasts tag 1 (ALU), then tag 4 (memory) on consecutive cycles.
- Memory holds valid continuously with tags 4, 5, 4, 5 and the CDB is never idle → after DEPTH=2 entries with memory contending against ALU traffic, mem_ready drops to 0. Entries are neither lost nor duplicated, and FIFO order survives wrap-around.
- Both sources stream continuously for 8 cycles → the grant strictly alternates, starting with ALU after reset.
- Both FIFOs hold 2 entries when flush=1 → next cycle cdb_valid=0, both readies are 1, and no stale tag is ever broadcast.
- ALU valid with tag 0 → alu_ready handshake completes and no broadcast occurs. Asserting rst low mid-stream clears cdb_valid immediately (asynchronously).
